// File: rtl/spi_flash_reader.sv
// SPI mode-0 master that issues READ (0x03) + 24-bit address to the config flash
// and streams the returned bytes out over a valid/ready interface.
module spi_flash_reader #(
    parameter int CLK_DIV  = 2,
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [23:0]         start_addr,
    input  logic [LEN_BITS-1:0] byte_count,
    output logic                busy,
    output logic                done,
    output logic [7:0]          rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                spi_cs_,
    output logic                spi_clk,
    output logic                spi_dq0,
    input  logic                spi_dq1
);

    localparam int DW = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        CMD      = 3'd2,
        XFER     = 3'd3,
        CS_HOLD  = 3'd4,
        CS_GAP   = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t              state_r, state_s;
    logic [DW-1:0]       div_r, div_s;
    logic [4:0]          bit_r, bit_s;
    logic [30:0]         shift_r, shift_s;
    logic [6:0]          rx_r, rx_s;
    logic [LEN_BITS-1:0] remain_r, remain_s;
    logic                cs_n_r, cs_n_s;
    logic                sclk_r, sclk_s;
    logic                dq0_r, dq0_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [7:0]          rd_data_r, rd_data_s;
    logic                rd_valid_r, rd_valid_s;
    logic                div_last_s;
    logic [31:0]         cmd_word_s;

    // State and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            div_r      <= '0;
            bit_r      <= 5'd0;
            shift_r    <= 31'd0;
            rx_r       <= 7'd0;
            remain_r   <= '0;
            cs_n_r     <= 1'b1;
            sclk_r     <= 1'b0;
            dq0_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_data_r  <= 8'd0;
            rd_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            rx_r       <= rx_s;
            remain_r   <= remain_s;
            cs_n_r     <= cs_n_s;
            sclk_r     <= sclk_s;
            dq0_r      <= dq0_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
        end
    end

    // Next-state and next-output logic for the whole transaction sequence.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        rx_s       = rx_r;
        remain_s   = remain_r;
        cs_n_s     = cs_n_r;
        sclk_s     = sclk_r;
        dq0_s      = dq0_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        rd_data_s  = rd_data_r;
        rd_valid_s = rd_valid_r;
        div_last_s = (div_r == DW'(CLK_DIV - 1));
        cmd_word_s = {8'h03, start_addr};

        if (rd_valid_r && rd_ready) begin
            rd_valid_s = 1'b0;
        end else begin
            rd_valid_s = rd_valid_r;
        end

        case (state_r)
            IDLE: begin
                if (start && (byte_count != '0)) begin
                    state_s  = CS_SETUP;
                    cs_n_s   = 1'b0;
                    sclk_s   = 1'b0;
                    busy_s   = 1'b1;
                    shift_s  = cmd_word_s[30:0];
                    dq0_s    = cmd_word_s[31];
                    remain_s = byte_count;
                    div_s    = '0;
                    bit_s    = 5'd0;
                end else if (start) begin
                    done_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CS_SETUP: begin
                if (div_last_s) begin
                    div_s   = '0;
                    state_s = CMD;
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            CMD: begin
                if (!div_last_s) begin
                    div_s = div_r + DW'(1);
                end else if (!sclk_r) begin
                    div_s  = '0;
                    sclk_s = 1'b1;
                end else begin
                    div_s   = '0;
                    sclk_s  = 1'b0;
                    shift_s = {shift_r[29:0], 1'b0};
                    if (bit_r == 5'd31) begin
                        bit_s   = 5'd0;
                        dq0_s   = 1'b0;
                        state_s = XFER;
                    end else begin
                        bit_s = bit_r + 5'd1;
                        dq0_s = shift_r[30];
                    end
                end
            end
            XFER: begin
                // A byte is never started while the previous one is still unclaimed.
                if (!sclk_r && (bit_r == 5'd0) && rd_valid_r) begin
                    div_s = '0;
                end else if (!div_last_s) begin
                    div_s = div_r + DW'(1);
                end else if (!sclk_r) begin
                    div_s  = '0;
                    sclk_s = 1'b1;
                    rx_s   = {rx_r[5:0], spi_dq1};
                    if (bit_r == 5'd7) begin
                        rd_data_s  = {rx_r, spi_dq1};
                        rd_valid_s = 1'b1;
                        remain_s   = remain_r - LEN_BITS'(1);
                    end else begin
                        rd_valid_s = rd_valid_s;
                    end
                end else begin
                    div_s  = '0;
                    sclk_s = 1'b0;
                    if (bit_r == 5'd7) begin
                        bit_s = 5'd0;
                        if (remain_r == '0) begin
                            state_s = CS_HOLD;
                        end else begin
                            state_s = XFER;
                        end
                    end else begin
                        bit_s = bit_r + 5'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (div_last_s) begin
                    div_s   = '0;
                    cs_n_s  = 1'b1;
                    state_s = CS_GAP;
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            CS_GAP: begin
                if (div_r == DW'(2 * CLK_DIV - 1)) begin
                    div_s   = '0;
                    state_s = DONE;
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            DONE: begin
                if (!rd_valid_r) begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign spi_cs_  = cs_n_r;
    assign spi_clk  = sclk_r;
    assign spi_dq0  = dq0_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader: one instance at CLK_DIV=2, one at CLK_DIV=1,
// each driven by a small behavioural READ-command flash model.
module tb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    int          total = 0;
    int          bad   = 0;

    // Instance 0 (CLK_DIV=2)
    logic        start0, rd_ready0, dq1_0;
    logic [23:0] addr0;
    logic [15:0] cnt0;
    logic        busy0, done0, rd_valid0, cs0, sclk0, mosi0;
    logic [7:0]  rd_data0;

    // Instance 1 (CLK_DIV=1)
    logic        start1, rd_ready1, dq1_1;
    logic [23:0] addr1;
    logic [15:0] cnt1;
    logic        busy1, done1, rd_valid1, cs1, sclk1, mosi1;
    logic [7:0]  rd_data1;

    spi_flash_reader #(.CLK_DIV(2), .LEN_BITS(16)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .start_addr(addr0), .byte_count(cnt0),
        .busy(busy0), .done(done0), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
        .spi_cs_(cs0), .spi_clk(sclk0), .spi_dq0(mosi0), .spi_dq1(dq1_0)
    );

    spi_flash_reader #(.CLK_DIV(1), .LEN_BITS(16)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .start_addr(addr1), .byte_count(cnt1),
        .busy(busy1), .done(done1), .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_ready(rd_ready1),
        .spi_cs_(cs1), .spi_clk(sclk1), .spi_dq0(mosi1), .spi_dq1(dq1_1)
    );

    logic [7:0]  fl0 [4];
    logic [7:0]  exp_b [4];
    logic [7:0]  fl1;
    int          rise0 = 0, rise1 = 0, fall0 = 0, fall1 = 0, csr0 = 0, csr1 = 0;
    int          dcnt0 = 0, dcnt1 = 0;
    logic [31:0] cmd0, cmd1;
    time         last0 = 0, prev0 = 0, last1 = 0, prev1 = 0;
    logic [7:0]  got0 [$];
    logic [7:0]  got1 [$];
    int          idx0, idx1;
    logic [7:0]  cur0;

    // Flash 0: cs fall restarts the command; MOSI captured on rising spi_clk.
    always @(posedge sclk0 or negedge cs0) begin
        if (sclk0) begin
            if (rise0 < 32) cmd0 = {cmd0[30:0], mosi0};
            rise0 = rise0 + 1;
            prev0 = last0;
            last0 = $time;
        end else begin
            rise0 = 0;
            fall0 = fall0 + 1;
        end
    end

    // Flash 0 drives the next data bit after each falling spi_clk once the command is in.
    always @(negedge sclk0) begin
        if (rise0 >= 32) begin
            idx0  = rise0 - 32;
            cur0  = fl0[(idx0 / 8) % 4];
            dq1_0 = cur0[7 - (idx0 % 8)];
        end
    end

    always @(posedge sclk1 or negedge cs1) begin
        if (sclk1) begin
            if (rise1 < 32) cmd1 = {cmd1[30:0], mosi1};
            rise1 = rise1 + 1;
            prev1 = last1;
            last1 = $time;
        end else begin
            rise1 = 0;
            fall1 = fall1 + 1;
        end
    end

    always @(negedge sclk1) begin
        if (rise1 >= 32) begin
            idx1  = rise1 - 32;
            dq1_1 = fl1[7 - (idx1 % 8)];
        end
    end

    always @(posedge cs0) csr0 = csr0 + 1;
    always @(posedge cs1) csr1 = csr1 + 1;

    always @(negedge clk) begin
        if (done0) dcnt0 = dcnt0 + 1;
        if (done1) dcnt1 = dcnt1 + 1;
    end

    always @(posedge clk) begin
        if (rd_valid0 && rd_ready0) got0.push_back(rd_data0);
        if (rd_valid1 && rd_ready1) got1.push_back(rd_data1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick0(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk);
        addr0 = a; cnt0 = n; start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
    endtask

    task automatic kick1(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk);
        addr1 = a; cnt1 = n; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done0 && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done0_seen", 32'(done0), 32'd1);
    endtask

    task automatic check_bytes0(input string tag, input int base);
        check({tag, "_count"}, 32'(got0.size() - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_b%0d", tag, i),
                  (base + i < got0.size()) ? 32'(got0[base + i]) : 32'hDEAD, 32'(exp_b[i]));
        end
    endtask

    int cyc, n, base, bd, bf, br, hold_bad, cshi;

    initial begin
        reset = 1'b1;
        start0 = 1'b0; start1 = 1'b0; addr0 = 24'd0; addr1 = 24'd0; cnt0 = 16'd0; cnt1 = 16'd0;
        rd_ready0 = 1'b1; rd_ready1 = 1'b1; dq1_0 = 1'b0; dq1_1 = 1'b0;
        fl0[0] = 8'hA5; fl0[1] = 8'h5A; fl0[2] = 8'h00; fl0[3] = 8'hFF; fl1 = 8'h3C;
        exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'h00; exp_b[3] = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_cs",      32'(cs0),       32'd1);
        check("rst_sclk",    32'(sclk0),     32'd0);
        check("rst_dq0",     32'(mosi0),     32'd0);
        check("rst_busy",    32'(busy0),     32'd0);
        check("rst_done",    32'(done0),     32'd0);
        check("rst_valid",   32'(rd_valid0), 32'd0);
        check("rst_data",    32'(rd_data0),  32'd0);
        check("rst_cs1",     32'(cs1),       32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 4-byte read, unstalled
        base = got0.size(); bd = dcnt0; bf = fall0; br = csr0;
        kick0(24'h012345, 16'd4);
        check("t1_busy",  32'(busy0), 32'd1);
        check("t1_cs",    32'(cs0),   32'd0);
        check("t1_sclk",  32'(sclk0), 32'd0);
        check("t1_dq0",   32'(mosi0), 32'd0);
        wait_done0(cyc);
        check("t1_cycles", 32'(cyc), 32'd265);
        check("t1_busy_end", 32'(busy0), 32'd0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", 32'(done0), 32'd0);
        repeat (3) @(negedge clk);
        check("t1_cmd", cmd0, 32'h03012345);
        check_bytes0("t1", base);
        check("t1_rises",  32'(rise0), 32'd64);
        check("t1_period", 32'(last0 - prev0), 32'd40);
        check("t1_dones",  32'(dcnt0 - bd), 32'd1);
        check("t1_csfall", 32'(fall0 - bf), 32'd1);
        check("t1_csrise", 32'(csr0 - br), 32'd1);

        // Backpressure on the first byte
        base = got0.size(); bd = dcnt0;
        rd_ready0 = 1'b0;
        kick0(24'h012345, 16'd4);
        n = 0;
        while (!rd_valid0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t2_valid", 32'(rd_valid0), 32'd1);
        repeat (3) @(posedge clk);
        hold_bad = 0;
        for (int i = 0; i < 97; i++) begin
            @(posedge clk);
            #1;
            if (sclk0 !== 1'b0 || cs0 !== 1'b0 || rd_data0 !== 8'hA5 || rd_valid0 !== 1'b1) hold_bad++;
        end
        check("t2_stall_hold", 32'(hold_bad), 32'd0);
        check("t2_stall_rises", 32'(rise0), 32'd40);
        @(negedge clk);
        rd_ready0 = 1'b1;
        wait_done0(cyc);
        repeat (3) @(negedge clk);
        check_bytes0("t2", base);
        check("t2_dones", 32'(dcnt0 - bd), 32'd1);

        // Zero-length request
        bd = dcnt0; bf = fall0;
        kick0(24'h000777, 16'd0);
        check("t3_done", 32'(done0), 32'd1);
        check("t3_busy", 32'(busy0), 32'd0);
        check("t3_cs",   32'(cs0),   32'd1);
        @(posedge clk);
        #1;
        check("t3_done_off", 32'(done0), 32'd0);
        repeat (5) @(negedge clk);
        check("t3_csfall", 32'(fall0 - bf), 32'd0);
        check("t3_dones",  32'(dcnt0 - bd), 32'd1);

        // Start pulse during CMD is ignored
        base = got0.size(); bd = dcnt0; bf = fall0;
        kick0(24'h012345, 16'd4);
        repeat (20) @(negedge clk);
        addr0 = 24'hABCDEF; cnt0 = 16'd1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(cyc);
        repeat (3) @(negedge clk);
        check("t4_cmd", cmd0, 32'h03012345);
        check_bytes0("t4", base);
        check("t4_dones",  32'(dcnt0 - bd), 32'd1);
        check("t4_csfall", 32'(fall0 - bf), 32'd1);

        // Reset during the second byte
        base = got0.size(); bd = dcnt0;
        kick0(24'h000100, 16'd4);
        n = 0;
        while (got0.size() < base + 1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_first_byte", 32'(got0.size() - base), 32'd1);
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t5_cs",    32'(cs0),       32'd1);
        check("t5_sclk",  32'(sclk0),     32'd0);
        check("t5_valid", 32'(rd_valid0), 32'd0);
        check("t5_busy",  32'(busy0),     32'd0);
        check("t5_data",  32'(rd_data0),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_no_partial", 32'(rd_valid0), 32'd0);
        check("t5_no_done",    32'(dcnt0 - bd), 32'd0);
        base = got0.size(); bd = dcnt0;
        kick0(24'h012345, 16'd4);
        wait_done0(cyc);
        check("t5_cycles", 32'(cyc), 32'd265);
        repeat (3) @(negedge clk);
        check("t5_cmd", cmd0, 32'h03012345);
        check_bytes0("t5", base);
        check("t5_dones", 32'(dcnt0 - bd), 32'd1);

        // CLK_DIV=1, single byte
        bd = dcnt1;
        kick1(24'h000010, 16'd1);
        cyc = 0; cshi = 0;
        while (!done1 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cs1 && !done1) cshi++;
        end
        check("t6_cycles", 32'(cyc), 32'd85);
        check("t6_csgap",  32'(cshi >= 2), 32'd1);
        repeat (3) @(negedge clk);
        check("t6_cmd",    cmd1, 32'h03000010);
        check("t6_count",  32'(got1.size()), 32'd1);
        check("t6_byte",   (got1.size() > 0) ? 32'(got1[0]) : 32'hDEAD, 32'h3C);
        check("t6_period", 32'(last1 - prev1), 32'd20);
        check("t6_dones",  32'(dcnt1 - bd), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
